// File: rtl/usb_evt_pkg.sv
// Shared constants for the USB event controller: register addresses, pin bit
// indices and CONFIG field layout.
package usb_evt_pkg;

    localparam logic [1:0] ADDR_LEVEL   = 2'd0;
    localparam logic [1:0] ADDR_CONFIG  = 2'd1;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int unsigned GPX_BIT = 0;
    localparam int unsigned INT_BIT = 1;

    localparam int unsigned CFG_GPX_RISE = 0;
    localparam int unsigned CFG_GPX_FALL = 1;
    localparam int unsigned CFG_INT_RISE = 2;
    localparam int unsigned CFG_INT_FALL = 3;

endpackage

// File: rtl/usb_evt_ctrl_if.sv
// Avalon-MM slave bus bundle for usb_evt_ctrl.
interface usb_evt_ctrl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/usb_pin_filter.sv
// Two-flop synchronizer plus stability filter for one asynchronous pin;
// emits the filtered level and single-cycle rise/fall pulses.
module usb_pin_filter #(
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] CNT_MAX = 8'(FILTER_CYCLES - 1);

    logic [1:0] sync_q;
    logic       level_q, level_d;
    logic [7:0] cnt_q, cnt_d;
    logic       s;

    assign s     = sync_q[1];
    assign level = level_q;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise    = 1'b0;
        fall    = 1'b0;
        if (s != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = s;
                rise    = s;
                fall    = ~s;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], pin};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/usb_evt_ctrl.sv
// USB host chip GPX/INT event controller: filtered levels, edge capture, IRQ masking.
// Optional IRQ holdoff after deassertion is enabled by defining USB_EVT_HOLDOFF_EN.
module usb_evt_ctrl
    import usb_evt_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES  = 4,
    parameter int unsigned HOLDOFF_CYCLES = 256
) (
    input  logic           clk,
    input  logic           reset,
    usb_evt_ctrl_if.slave  bus,
    input  logic           gpx_in,
    input  logic           int_in,
    output logic           irq
);

    logic gpx_level, gpx_rise, gpx_fall;
    logic int_level, int_rise, int_fall;

    usb_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_gpx_filter (
        .clk   (clk),
        .reset (reset),
        .pin   (gpx_in),
        .level (gpx_level),
        .rise  (gpx_rise),
        .fall  (gpx_fall)
    );

    usb_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_int_filter (
        .clk   (clk),
        .reset (reset),
        .pin   (int_in),
        .level (int_level),
        .rise  (int_rise),
        .fall  (int_fall)
    );

    logic [3:0]  config_q, config_d;
    logic [1:0]  mask_q, mask_d;
    logic [1:0]  edgecap_q, edgecap_d;
    logic [31:0] readdata_q, readdata_d;
    logic [1:0]  cap_set, w1c;
    logic [31:0] rd_mux;
    logic        wr, rd, irq_raw;
    logic        unused_wdata;

    assign wr           = bus.chipselect & ~bus.write_n;
    assign rd           = bus.chipselect & bus.write_n;
    assign unused_wdata = ^bus.writedata[31:4];
    assign bus.readdata = readdata_q;
    assign irq_raw      = |(edgecap_q & mask_q);

    always_comb begin
        cap_set          = '0;
        cap_set[GPX_BIT] = (gpx_rise & config_q[CFG_GPX_RISE]) |
                           (gpx_fall & config_q[CFG_GPX_FALL]);
        cap_set[INT_BIT] = (int_rise & config_q[CFG_INT_RISE]) |
                           (int_fall & config_q[CFG_INT_FALL]);

        config_d = config_q;
        mask_d   = mask_q;
        w1c      = '0;
        if (wr) begin
            case (bus.address)
                ADDR_CONFIG:  config_d = bus.writedata[3:0];
                ADDR_MASK:    mask_d   = bus.writedata[1:0];
                ADDR_EDGECAP: w1c      = bus.writedata[1:0];
                default:      ;
            endcase
        end
        // A capture in the same cycle as its clear keeps the bit set.
        edgecap_d = (edgecap_q & ~w1c) | cap_set;

        rd_mux = '0;
        case (bus.address)
            ADDR_LEVEL:   rd_mux = {30'd0, int_level, gpx_level};
            ADDR_CONFIG:  rd_mux = {28'd0, config_q};
            ADDR_MASK:    rd_mux = {30'd0, mask_q};
            ADDR_EDGECAP: rd_mux = {30'd0, edgecap_q};
            default:      rd_mux = '0;
        endcase
        readdata_d = rd ? rd_mux : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            config_q   <= '0;
            mask_q     <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            config_q   <= config_d;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

`ifdef USB_EVT_HOLDOFF_EN
    localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_CYCLES);

    logic [15:0] hold_q, hold_d;
    logic        irq_next_raw;

    assign irq          = irq_raw & (hold_q == 16'd0);
    assign irq_next_raw = |(edgecap_d & mask_d);

    // Load on the edge where irq drops so the low window starts immediately.
    always_comb begin
        hold_d = (hold_q != 16'd0) ? hold_q - 16'd1 : 16'd0;
        if (irq && !irq_next_raw) begin
            hold_d = HOLD_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic unused_holdoff;

    assign irq            = irq_raw;
    assign unused_holdoff = (HOLDOFF_CYCLES != 0);
`endif

endmodule
